// File: rtl/cgra_kernel_dispatcher.sv
// cgra_kernel_dispatcher
// Kernel-launch sequencer between the CGRA peripheral-register slots and the
// reconfigurable-cell columns. Each slot's kernel ID is arbitrated round-robin,
// its configuration word is read from kernel memory and decoded, and the
// lowest-indexed free columns are allocated and started. Completion is
// reported per slot once every column it owns has signalled done.
//
// Optional feature macro: CGRA_DISPATCH_PERF_EN
//   When defined, a saturating 32-bit cycle counter per slot is exported on
//   perf_cycles_o. It measures from grant until the slot's last column frees.
module cgra_kernel_dispatcher #(
  parameter  int N_SLOTS        = 2,
  parameter  int N_COL          = 4,
  parameter  int IMEM_N_LINES   = 128,
  parameter  int RCS_NUM_CREG   = 32,
  parameter  int KER_CONF_N_REG = 16,
  localparam int SLOT_W         = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int KID_W          = $clog2(KER_CONF_N_REG),
  localparam int ADD_W          = $clog2(IMEM_N_LINES),
  localparam int NI_W           = $clog2(RCS_NUM_CREG),
  localparam int KMEM_WIDTH     = N_COL + ADD_W + NI_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SLOTS-1:0]         req_valid_i,
  input  logic [N_SLOTS*KID_W-1:0]   req_ker_id_i,
  output logic [N_SLOTS-1:0]         req_ready_o,
  output logic                       kmem_req_o,
  output logic [KID_W-1:0]           kmem_addr_o,
  input  logic [KMEM_WIDTH-1:0]      kmem_rdata_i,
  output logic [N_COL-1:0]           col_start_o,
  output logic [ADD_W-1:0]           col_imem_add_o,
  output logic [NI_W-1:0]            col_n_instr_o,
  output logic [N_COL-1:0]           col_busy_o,
  input  logic [N_COL-1:0]           col_done_i,
  output logic [N_SLOTS-1:0]         slot_done_o,
  output logic [N_SLOTS-1:0]         slot_err_o,
  output logic                       busy_o
`ifdef CGRA_DISPATCH_PERF_EN
  ,
  output logic [N_SLOTS*32-1:0]      perf_cycles_o
`endif
);

  localparam int CNT_W = $clog2(N_COL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ALLOC,
    S_LAUNCH
  } state_e;

  state_e                        state_q;
  logic [SLOT_W-1:0]             slot_q;
  logic [SLOT_W-1:0]             rrPtr_q;
  logic [KID_W-1:0]              kerId_q;
  logic [CNT_W-1:0]              need_q;
  logic [ADD_W-1:0]              pendAdd_q;
  logic [NI_W-1:0]               pendInstr_q;

  logic                          kmemReq_q;
  logic [KID_W-1:0]              kmemAddr_q;
  logic [N_COL-1:0]              colStart_q;
  logic [ADD_W-1:0]              colAdd_q;
  logic [NI_W-1:0]               colInstr_q;
  logic [N_SLOTS-1:0]            slotErr_q;
  logic [N_SLOTS-1:0]            slotDone_q;

  logic [N_COL-1:0]              freeMask_q;
  logic [N_COL-1:0]              freeMask_d;
  logic [N_COL-1:0][SLOT_W-1:0]  owner_q;
  logic [N_SLOTS-1:0]            inflight_q;
  logic [N_SLOTS-1:0]            inflight_d;

  logic [N_SLOTS-1:0]            eligible;
  logic                          grantVld;
  logic [SLOT_W-1:0]             grantSlot;
  logic                          grantFire;
  logic [KID_W-1:0]              grantId;

  logic [NI_W-1:0]               decInstr;
  logic [ADD_W-1:0]              decAdd;
  logic [N_COL-1:0]              decMask;
  logic [CNT_W-1:0]              decNeed;
  logic [CNT_W-1:0]              freeCnt;
  logic                          decErr;

  logic [N_COL-1:0]              allocSel;
  logic                          allocFire;
  logic [N_COL-1:0]              doneEff;
  logic [N_SLOTS-1:0][N_COL-1:0] owned;
  logic [N_SLOTS-1:0]            slotFinish;

  assign eligible = req_valid_i & ~inflight_q;

  // Round-robin search starting at the priority pointer for a requesting idle slot
  always_comb begin
    logic [SLOT_W-1:0] cand;
    grantVld  = 1'b0;
    grantSlot = '0;
    cand      = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      cand = SLOT_W'((int'(rrPtr_q) + i) % N_SLOTS);
      if (!grantVld && eligible[cand]) begin
        grantVld  = 1'b1;
        grantSlot = cand;
      end
    end
  end

  assign grantFire   = (state_q == S_IDLE) && grantVld;
  assign grantId     = req_ker_id_i[int'(grantSlot)*KID_W +: KID_W];
  assign req_ready_o = (grantFire && !rst_i) ? (N_SLOTS'(1) << grantSlot) : '0;

  assign decInstr = kmem_rdata_i[NI_W-1:0];
  assign decAdd   = kmem_rdata_i[NI_W+ADD_W-1:NI_W];
  assign decMask  = kmem_rdata_i[KMEM_WIDTH-1:KMEM_WIDTH-N_COL];

  // Column counts: how many the fetched kernel needs and how many are free now
  always_comb begin
    decNeed = '0;
    freeCnt = '0;
    for (int c = 0; c < N_COL; c++) begin
      decNeed = decNeed + CNT_W'(decMask[c]);
      freeCnt = freeCnt + CNT_W'(freeMask_q[c]);
    end
  end

  assign decErr = (kerId_q == '0) || (decNeed == '0) || (decInstr == '0);

  // Pick the lowest-indexed free columns until the kernel's demand is met
  always_comb begin
    logic [CNT_W-1:0] taken;
    allocSel = '0;
    taken    = '0;
    for (int c = 0; c < N_COL; c++) begin
      if (freeMask_q[c] && (taken < need_q)) begin
        allocSel[c] = 1'b1;
        taken       = taken + CNT_W'(1);
      end
    end
  end

  assign allocFire = (state_q == S_ALLOC) && (freeCnt >= need_q);
  assign doneEff   = col_done_i & ~freeMask_q;

  // A slot finishes when done pulses retire the last of its owned columns
  always_comb begin
    owned      = '0;
    slotFinish = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      for (int c = 0; c < N_COL; c++) begin
        owned[s][c] = !freeMask_q[c] && (owner_q[c] == SLOT_W'(s));
      end
      slotFinish[s] = inflight_q[s] && (|(owned[s] & doneEff)) &&
                      ((owned[s] & ~doneEff) == '0);
    end
  end

  assign freeMask_d = (freeMask_q | doneEff) & ~(allocFire ? allocSel : '0);
  assign inflight_d = (inflight_q & ~slotFinish) |
                      (allocFire ? (N_SLOTS'(1) << slot_q) : '0);

  // Launch sequencer: grant, fetch, decode, allocate, launch, with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      rrPtr_q     <= '0;
      kerId_q     <= '0;
      need_q      <= '0;
      pendAdd_q   <= '0;
      pendInstr_q <= '0;
      kmemReq_q   <= 1'b0;
      kmemAddr_q  <= '0;
      colStart_q  <= '0;
      colAdd_q    <= '0;
      colInstr_q  <= '0;
      slotErr_q   <= '0;
    end else begin
      kmemReq_q  <= 1'b0;
      colStart_q <= '0;
      slotErr_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (grantFire) begin
            slot_q     <= grantSlot;
            kerId_q    <= grantId;
            kmemReq_q  <= 1'b1;
            kmemAddr_q <= grantId;
            rrPtr_q    <= (grantSlot == SLOT_W'(N_SLOTS - 1)) ? '0 : grantSlot + SLOT_W'(1);
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (decErr) begin
            slotErr_q <= N_SLOTS'(1) << slot_q;
            state_q   <= S_IDLE;
          end else begin
            need_q      <= decNeed;
            pendAdd_q   <= decAdd;
            pendInstr_q <= decInstr;
            state_q     <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          if (allocFire) begin
            colStart_q <= allocSel;
            colAdd_q   <= pendAdd_q;
            colInstr_q <= pendInstr_q;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Column ownership, free mask and per-slot in-flight tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      freeMask_q <= '1;
      owner_q    <= '0;
      inflight_q <= '0;
      slotDone_q <= '0;
    end else begin
      freeMask_q <= freeMask_d;
      inflight_q <= inflight_d;
      slotDone_q <= slotFinish;
      for (int c = 0; c < N_COL; c++) begin
        if (allocFire && allocSel[c]) begin
          owner_q[c] <= slot_q;
        end
      end
    end
  end

  assign kmem_req_o     = kmemReq_q;
  assign kmem_addr_o    = kmemAddr_q;
  assign col_start_o    = colStart_q;
  assign col_imem_add_o = colAdd_q;
  assign col_n_instr_o  = colInstr_q;
  assign col_busy_o     = ~freeMask_q;
  assign slot_done_o    = slotDone_q;
  assign slot_err_o     = slotErr_q;
  assign busy_o         = (state_q != S_IDLE) || (|(~freeMask_q));

`ifdef CGRA_DISPATCH_PERF_EN
  logic [N_SLOTS-1:0][31:0] perf_q;

  // Per-slot cycle counters: restart at grant, run while owned or in flight, saturate
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      for (int s = 0; s < N_SLOTS; s++) begin
        if (grantFire && (grantSlot == SLOT_W'(s))) begin
          perf_q[s] <= 32'd1;
        end else if ((((state_q != S_IDLE) && (slot_q == SLOT_W'(s))) || inflight_q[s]) &&
                     (perf_q[s] != 32'hFFFF_FFFF)) begin
          perf_q[s] <= perf_q[s] + 32'd1;
        end
      end
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: doc/cgra_kernel_dispatcher.md
Name: cgra_kernel_dispatcher

Overview:
Parametrised kernel-launch sequencer. It sits between the CGRA peripheral-register slots and the reconfigurable-cell (RC) columns. Per slot, it accepts a kernel ID, fetches that kernel's configuration word from kernel memory, and decodes the column-count, instruction-memory (imem) start-address and instruction-count fields. It then allocates any free columns (relocatable, not fixed positions), launches them, and signals slot completion when every allocated column reports done.

Parameters:
N_SLOTS, 2, number of independent request slots (≥1)
N_COL, 4, number of RC columns
IMEM_N_LINES, 128, instruction-memory lines per RC
RCS_NUM_CREG, 32, maximum instructions per kernel
KER_CONF_N_REG, 16, kernel-memory depth; entry 0 reserved/invalid
Derived (localparam): SLOT_W=max(1,clog2(N_SLOTS)), KID_W=clog2(KER_CONF_N_REG), ADD_W=clog2(IMEM_N_LINES), NI_W=clog2(RCS_NUM_CREG), KMEM_WIDTH=N_COL+ADD_W+NI_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_valid_i  in  N_SLOTS  per-slot launch request
req_ker_id_i  in  N_SLOTS*KID_W  per-slot kernel ID
req_ready_o  out  N_SLOTS  per-slot request accepted this cycle
kmem_req_o  out  1  kernel-memory read strobe
kmem_addr_o  out  KID_W  kernel-memory address
kmem_rdata_i  in  KMEM_WIDTH  read data, valid exactly 1 cycle after kmem_req_o
col_start_o  out  N_COL  one-cycle start pulse per column
col_imem_add_o  out  ADD_W  kernel start address (valid with any col_start_o)
col_n_instr_o  out  NI_W  instruction count (valid with any col_start_o)
col_busy_o  out  N_COL  column allocated
col_done_i  in  N_COL  one-cycle done pulse per column
slot_done_o  out  N_SLOTS  one-cycle kernel-complete pulse
slot_err_o  out  N_SLOTS  one-cycle rejected-kernel pulse
busy_o  out  1  FSM not IDLE, or any column allocated

Behaviour:
- Clocking/reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: all outputs 0; FSM=IDLE; free mask all-ones; round-robin pointer=0; no slots in flight.
- Kernel-word decode:
  - n_instr = bits [NI_W-1:0]
  - imem_add = bits [NI_W+ADD_W-1:NI_W]
  - col_mask = top N_COL bits
  - required columns k = popcount(col_mask)
- FSM states and transitions:
  - IDLE: round-robin arbitration over slots with req_valid_i=1 and no kernel in flight. Winner gets a req_ready_o pulse; its ID is latched. → FETCH. Priority after a grant moves to winner+1 (mod N_SLOTS).
  - FETCH: kmem_req_o=1, kmem_addr_o=latched ID, for 1 cycle. → DECODE.
  - DECODE: capture kmem_rdata_i. Error if ID==0, k==0 or n_instr==0: pulse slot_err_o[slot], → IDLE. Otherwise → ALLOC.
  - ALLOC: wait until popcount(free mask) ≥ k. Select the k lowest-indexed free columns. → LAUNCH.
  - LAUNCH: pulse col_start_o on the selected columns. Set col_busy_o, record the owning slot per column, mark the slot in flight. → IDLE.
- Total launch latency: 4 cycles from grant to col_start_o when columns are available.
- Completion:
  - col_done_i[c] with col_busy_o[c]=1 frees column c on the next edge.
  - col_done_i on a non-busy column is ignored.
  - When the last column owned by a slot frees, slot_done_o[slot] pulses in that same update cycle and the in-flight flag clears.
  - A slot then becomes requestable one cycle later.
- Simultaneous done and allocation: ALLOC evaluates the registered free mask. A column freed in cycle t is allocatable from t+1. Done and launch on different columns in the same cycle are both honoured.
- Starvation: a kernel waiting in ALLOC blocks further grants (in-order, no bypass).
- Reset mid-operation: all allocation, in-flight and FSM state is lost. No done/err pulses are generated for aborted kernels.

Optional Feature:
CGRA_DISPATCH_PERF_EN
- Defined: adds output perf_cycles_o (N_SLOTS*32). Each slot has a 32-bit counter that:
  - clears on grant;
  - increments every cycle while the slot is granted or in flight;
  - saturates at 0xFFFFFFFF;
  - holds its value after slot_done_o.
- Undefined: port absent; no counters.

Test Plan:
- Kmem[3]: mask=4'b0011, add=10, n=5. Slot0 requests ID 3 → col_start_o=4'b0011 at grant+4, col_imem_add_o=10, col_n_instr_o=5. col_done_i 0 then 1 → slot_done_o[0] pulses in the cycle after the second done.
- Slot0 requests ID 0 → slot_err_o[0] pulse at grant+3; no col_start_o; busy_o returns to 0.
- Kmem[5]: mask=4'b1111, n=8. Slot0 holds columns 0,1; slot1 requests ID 5 → waits in ALLOC; after slot0 completes, launches all four columns 1 cycle later.
- Both slots request simultaneously from reset → slot0 granted first, slot1 next. With both requesting again after completion → slot1's grant precedes slot0's after a slot0 grant (round-robin).
- Assert rst_i while in ALLOC with columns busy → all outputs 0 immediately; a new request afterwards launches on columns 0 upward.
- PERF_EN: launch ID 3 with done 20 cycles after start → perf_cycles_o[slot0]=25 (4 launch cycles, 20 run cycles, 1 free cycle), holding afterwards.
